// File: rtl/i2c_target_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_pkg : shared types and constants for the I2C target controller
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_WR       = 4'd4,
    ST_W_ACK    = 4'd5,
    ST_RD       = 4'd6,
    ST_R_ACK    = 4'd7,
    ST_IGNORE   = 4'd8
  } i2c_tgt_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_target_ctrl_glitch_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_glitch_filter : 2-flop synchronizer, FILT_LEN-sample filter, edge pulses
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module i2c_glitch_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]          r_sync;
  logic [FILT_LEN-1:0] w_window;
  logic                w_all_hi;
  logic                w_all_lo;
  logic                r_level;
  logic                r_rise;
  logic                r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], din};
    end
  end

  // Window = newest synchronized sample plus FILT_LEN-1 older ones
  generate
    if (FILT_LEN == 1) begin : g_single
      assign w_window = r_sync[1];
    end else begin : g_multi
      logic [FILT_LEN-2:0] r_hist;
      assign w_window = {r_hist, r_sync[1]};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hist <= '1;
        end else begin
          r_hist <= w_window[FILT_LEN-2:0];
        end
      end
    end
  endgenerate

  assign w_all_hi = &w_window;
  assign w_all_lo = ~|w_window;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_all_hi & ~r_level;
      r_fall <= w_all_lo & r_level;
      if (w_all_hi) begin
        r_level <= 1'b1;
      end else if (w_all_lo) begin
        r_level <= 1'b0;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/i2c_target_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_target_ctrl : I2C target mapping bus transfers onto an 8-bit register port
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module i2c_target_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (scl_i),
    .level (w_scl_lvl),
    .rise  (w_scl_rise),
    .fall  (w_scl_fall)
  );

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sda_i),
    .level (w_sda_lvl),
    .rise  (w_sda_rise),
    .fall  (w_sda_fall)
  );

  i2c_tgt_state_e r_state, w_state_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic [7:0] r_ptr, w_ptr_nx;
  logic [7:0] r_wdata, w_wdata_nx;
  logic       r_sda_oe, w_oe_nx;
  logic       r_reg_wr, w_wr_nx;
  logic       r_reg_rd, w_rd_nx;
  logic       r_busy, w_busy_nx;
  logic       r_rw, w_rw_nx;
  logic       r_inc, w_inc_nx;
  logic       r_rd_load;
  logic       w_start, w_stop, w_addr_match;
  logic [7:0] w_byte;

  assign w_start      = w_sda_fall & w_scl_lvl;
  assign w_stop       = w_sda_rise & w_scl_lvl;
  assign w_byte       = {r_shift[6:0], w_sda_lvl};
  assign w_addr_match = (w_byte[7:1] == TARGET_ADDR) && (w_byte[7:1] != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // ACK states use r_cnt as a phase: 0 = awaiting ACK-slot fall, 1/2 = later
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_ptr_nx   = r_ptr;
    w_oe_nx    = r_sda_oe;
    w_wr_nx    = 1'b0;
    w_wdata_nx = r_wdata;
    w_rd_nx    = 1'b0;
    w_busy_nx  = r_busy;
    w_rw_nx    = r_rw;
    w_inc_nx   = r_inc;
    if (r_rd_load) begin
      w_shift_nx = reg_rdata;
    end
    if (w_start) begin
      w_state_nx = ST_ADDR;
      w_cnt_nx   = 4'd0;
      w_oe_nx    = 1'b0;
      w_inc_nx   = 1'b0;
    end else if (w_stop) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = 4'd0;
      w_oe_nx    = 1'b0;
      w_inc_nx   = 1'b0;
      w_busy_nx  = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nx = 4'd0;
              if (r_state == ST_ADDR) begin
                if (w_addr_match) begin
                  w_state_nx = ST_ADDR_ACK;
                  w_rw_nx    = w_byte[0];
                  w_rd_nx    = (w_byte[0] == I2C_RW_READ);
                end else begin
                  w_state_nx = ST_IGNORE;
                end
              end else if (r_state == ST_PTR) begin
                w_ptr_nx   = w_byte;
                w_state_nx = ST_W_ACK;
              end else begin
                w_wr_nx    = 1'b1;
                w_wdata_nx = w_byte;
                w_inc_nx   = 1'b1;
                w_state_nx = ST_W_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_W_ACK: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              w_oe_nx  = 1'b1;
              w_cnt_nx = 4'd1;
              if (r_state == ST_ADDR_ACK) begin
                w_busy_nx = 1'b1;
              end
            end else begin
              w_cnt_nx = 4'd0;
              w_oe_nx  = 1'b0;
              if (r_state == ST_W_ACK) begin
                w_state_nx = ST_WR;
                w_inc_nx   = 1'b0;
                if (r_inc) begin
                  w_ptr_nx = r_ptr + 8'd1;
                end
              end else if (r_rw == I2C_RW_READ) begin
                w_oe_nx    = ~r_shift[7];
                w_state_nx = ST_RD;
              end else begin
                w_state_nx = ST_PTR;
              end
            end
          end
        end
        ST_RD: begin
          if (w_scl_rise) begin
            w_cnt_nx = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nx   = 4'd0;
              w_state_nx = ST_R_ACK;
            end
          end else if (w_scl_fall && (r_cnt != 4'd0)) begin
            w_shift_nx = {r_shift[6:0], 1'b0};
            w_oe_nx    = ~r_shift[6];
          end
        end
        ST_R_ACK: begin
          if (w_scl_fall && (r_cnt == 4'd0)) begin
            w_oe_nx  = 1'b0;
            w_cnt_nx = 4'd1;
          end else if (w_scl_rise && (r_cnt == 4'd1)) begin
            if (w_sda_lvl == I2C_ACK) begin
              w_ptr_nx = r_ptr + 8'd1;
              w_rd_nx  = 1'b1;
              w_cnt_nx = 4'd2;
            end else begin
              w_oe_nx    = 1'b0;
              w_cnt_nx   = 4'd0;
              w_state_nx = ST_IGNORE;
            end
          end else if (w_scl_fall && (r_cnt == 4'd2)) begin
            w_oe_nx    = ~r_shift[7];
            w_cnt_nx   = 4'd0;
            w_state_nx = ST_RD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 8'd0;
      r_cnt     <= 4'd0;
      r_ptr     <= 8'd0;
      r_wdata   <= 8'd0;
      r_sda_oe  <= 1'b0;
      r_reg_wr  <= 1'b0;
      r_reg_rd  <= 1'b0;
      r_rd_load <= 1'b0;
      r_busy    <= 1'b0;
      r_rw      <= 1'b0;
      r_inc     <= 1'b0;
    end else begin
      r_shift   <= w_shift_nx;
      r_cnt     <= w_cnt_nx;
      r_ptr     <= w_ptr_nx;
      r_wdata   <= w_wdata_nx;
      r_sda_oe  <= w_oe_nx;
      r_reg_wr  <= w_wr_nx;
      r_reg_rd  <= w_rd_nx;
      r_rd_load <= r_reg_rd;
      r_busy    <= w_busy_nx;
      r_rw      <= w_rw_nx;
      r_inc     <= w_inc_nx;
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_addr  = r_ptr;
  assign reg_wr    = r_reg_wr;
  assign reg_wdata = r_wdata;
  assign reg_rd    = r_reg_rd;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_target_ctrl : bus-initiator bench with register-strobe scoreboard
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_i2c_target_ctrl;
  import i2c_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       scl_drv, sda_drv, scl_glitch;
  logic       scl_in, sda_bus;
  logic       sda_oe, reg_wr, reg_rd, busy;
  logic [7:0] reg_addr, reg_wdata, rdata_q;
  logic [7:0] mem [256];

  assign scl_in  = scl_drv & ~scl_glitch;
  assign sda_bus = sda_drv & ~sda_oe;

  i2c_target_ctrl #(.TARGET_ADDR(7'h50), .FILT_LEN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_in),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .reg_rd    (reg_rd),
    .reg_rdata (rdata_q),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: data valid only during the cycle after reg_rd
  always @(posedge clk) rdata_q <= reg_rd ? mem[reg_addr] : 8'hEE;

  typedef struct {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] abyte;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       match;
  } wvec_t;

  ev_t   exp_q[$];
  wvec_t vecs[5];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    oe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sample_strobes();
    ev_t e;
    if (sda_oe) oe_cnt++;
    if (reg_wr && reg_rd) check("wr_rd_overlap", 1, 0);
    if (reg_wr || reg_rd) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {reg_wr, reg_rd, reg_addr}, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {31'd0, reg_wr}, {31'd0, e.is_wr});
        check("strobe_addr", {24'd0, reg_addr}, {24'd0, e.addr});
        if (e.is_wr) check("strobe_wdata", {24'd0, reg_wdata}, {24'd0, e.data});
      end
    end
  endtask

  task automatic clks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      sample_strobes();
    end
  endtask

  task automatic push_ev(input logic is_wr, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = is_wr;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; clks(10);
    scl_drv = 1'b1; clks(10);
    sda_drv = 1'b0; clks(10);
    scl_drv = 1'b0; clks(10);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; clks(10);
    scl_drv = 1'b1; clks(10);
    sda_drv = 1'b1; clks(10);
  endtask

  task automatic xfer_bit(input logic b, input logic glitch, output logic s);
    sda_drv = b;    clks(10);
    scl_drv = 1'b1; clks(5);
    if (glitch) begin
      scl_glitch = 1'b1; clks(1);
      scl_glitch = 1'b0; clks(4);
    end else begin
      clks(5);
    end
    s = sda_bus;    clks(10);
    scl_drv = 1'b0; clks(10);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], gmask[i], dummy);
    xfer_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic dummy;
    for (int i = 7; i >= 0; i--) xfer_bit(1'b1, 1'b0, d[i]);
    xfer_bit(nack, 1'b0, dummy);
  endtask

  initial begin
    logic       ack, exp_ack;
    logic [7:0] rd;
    int         oe_base;

    vecs[0] = '{8'hA0, 8'h10, 8'hA5, 8'h3C, 1'b1};
    vecs[1] = '{8'hA0, 8'hFF, 8'h11, 8'h22, 1'b1};
    vecs[2] = '{8'hA2, 8'hFF, 8'hFF, 8'hFF, 1'b0};
    vecs[3] = '{8'h00, 8'h12, 8'h34, 8'h56, 1'b0};
    vecs[4] = '{8'hA0, 8'h7E, 8'h00, 8'hFF, 1'b1};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'h5A;
    mem[8'h21] = 8'hC3;
    mem[8'h50] = 8'h0F;

    rst_n = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1; scl_glitch = 1'b0;
    clks(5);
    rst_n = 1'b1;
    clks(10);
    check("rst_sda_oe", {31'd0, sda_oe}, 0);
    check("rst_reg_wr", {31'd0, reg_wr}, 0);
    check("rst_reg_rd", {31'd0, reg_rd}, 0);
    check("rst_wdata", {24'd0, reg_wdata}, 0);
    check("rst_addr", {24'd0, reg_addr}, 0);
    check("rst_busy", {31'd0, busy}, 0);

    for (int v = 0; v < 5; v++) begin
      exp_ack = vecs[v].match ? I2C_ACK : I2C_NACK;
      oe_base = oe_cnt;
      if (vecs[v].match) begin
        push_ev(1'b1, vecs[v].ptr, vecs[v].d0);
        push_ev(1'b1, vecs[v].ptr + 8'd1, vecs[v].d1);
      end
      bus_start();
      write_byte(vecs[v].abyte, 8'h00, ack);
      check("vec_addr_ack", {31'd0, ack}, {31'd0, exp_ack});
      write_byte(vecs[v].ptr, 8'h00, ack);
      check("vec_ptr_ack", {31'd0, ack}, {31'd0, exp_ack});
      check("vec_busy_mid", {31'd0, busy}, {31'd0, vecs[v].match});
      write_byte(vecs[v].d0, 8'h00, ack);
      check("vec_d0_ack", {31'd0, ack}, {31'd0, exp_ack});
      write_byte(vecs[v].d1, 8'h00, ack);
      check("vec_d1_ack", {31'd0, ack}, {31'd0, exp_ack});
      bus_stop();
      clks(10);
      check("vec_busy_end", {31'd0, busy}, 0);
      if (vecs[v].match) check("vec_ptr_end", {24'd0, reg_addr}, {24'd0, vecs[v].ptr + 8'd2});
      else check("vec_no_oe", oe_cnt - oe_base, 0);
    end

    // Pointer write, repeated START, two-byte read
    bus_start();
    write_byte(8'hA0, 8'h00, ack);
    check("rd_wa_ack", {31'd0, ack}, 0);
    write_byte(8'h20, 8'h00, ack);
    check("rd_ptr_ack", {31'd0, ack}, 0);
    push_ev(1'b0, 8'h20, 8'h00);
    push_ev(1'b0, 8'h21, 8'h00);
    bus_start();
    write_byte(8'hA1, 8'h00, ack);
    check("rd_ra_ack", {31'd0, ack}, 0);
    check("rd_busy", {31'd0, busy}, 1);
    read_byte(1'b0, rd);
    check("rd_byte0", {24'd0, rd}, 32'h5A);
    read_byte(1'b1, rd);
    check("rd_byte1", {24'd0, rd}, 32'hC3);
    check("rd_released", {31'd0, sda_oe}, 0);
    bus_stop();
    clks(10);
    check("rd_ptr_end", {24'd0, reg_addr}, 32'h21);

    // Glitched SCL during address, pointer and data bits
    push_ev(1'b1, 8'h40, 8'h96);
    bus_start();
    write_byte(8'hA0, 8'h81, ack);
    check("gl_addr_ack", {31'd0, ack}, 0);
    write_byte(8'h40, 8'h24, ack);
    check("gl_ptr_ack", {31'd0, ack}, 0);
    write_byte(8'h96, 8'h5A, ack);
    check("gl_data_ack", {31'd0, ack}, 0);
    bus_stop();
    clks(10);
    check("gl_ptr_end", {24'd0, reg_addr}, 32'h41);

    // STOP after a partial data byte
    bus_start();
    write_byte(8'hA0, 8'h00, ack);
    write_byte(8'h50, 8'h00, ack);
    check("ab_ptr_ack", {31'd0, ack}, 0);
    xfer_bit(1'b1, 1'b0, ack);
    xfer_bit(1'b0, 1'b0, ack);
    xfer_bit(1'b1, 1'b0, ack);
    xfer_bit(1'b1, 1'b0, ack);
    bus_stop();
    clks(10);
    check("ab_busy", {31'd0, busy}, 0);
    check("ab_ptr", {24'd0, reg_addr}, 32'h50);
    check("ab_state", {28'd0, dut.r_state}, {28'd0, ST_IDLE});

    // Reset while the target is driving a 0 in a read byte
    push_ev(1'b0, 8'h50, 8'h00);
    bus_start();
    write_byte(8'hA1, 8'h00, ack);
    check("rs_addr_ack", {31'd0, ack}, 0);
    check("rs_driving0", {31'd0, sda_oe}, 1);
    rst_n = 1'b0;
    #1;
    check("rs_async_oe", {31'd0, sda_oe}, 0);
    check("rs_state", {28'd0, dut.r_state}, {28'd0, ST_IDLE});
    check("rs_busy", {31'd0, busy}, 0);
    check("rs_ptr", {24'd0, reg_addr}, 0);
    clks(3);
    rst_n = 1'b1;
    sda_drv = 1'b1;
    scl_drv = 1'b1;
    clks(20);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
